// File: rtl/frame_pkg.sv
// Shared definitions for the byte-strobe frame link.
// Used by both the reader (transmit) and writer (receive) sides.
package frame_pkg;

  localparam int BYTES_DEF = 16;
  localparam int SLOW_DEF  = 2;
  localparam int FRAME_LEN = BYTES_DEF + SLOW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE
  } state_t;

endpackage

// File: rtl/frame_reader_if.sv
// Load/start/link bundle of the frame reader.
// master drives loads and start, slave drives the link side.
interface frame_reader_if;

  logic [7:0] fData;
  logic       fVal;
  logic [7:0] sData;
  logic       sVal;
  logic       start;
  logic [7:0] oData;
  logic       strob;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       errStart;

  modport master (
    output fData, fVal, sData, sVal, start,
    input  oData, strob, busy, done, ovf, errStart
  );

  modport slave (
    input  fData, fVal, sData, sVal, start,
    output oData, strob, busy, done, ovf, errStart
  );

endinterface

// File: rtl/strob_phase_timer.sv
// Phase down-counter: load a cycle count, report when it reads zero.
// Holds at zero until reloaded.
module strob_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load wins, otherwise count down and stick at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/frame_reader.sv
// Transmit side of the byte-strobe frame link: buffers fast and
// slow bytes, then serialises them with a slow SETUP/HIGH/LOW strobe.
module frame_reader
  import frame_pkg::*;
#(
  parameter int BYTES     = BYTES_DEF,
  parameter int SLOW      = SLOW_DEF,
  parameter int SETUP_CYC = 2,
  parameter int HI_CYC    = 4,
  parameter int LO_CYC    = 4
) (
  input logic           clk,
  input logic           rst,
  frame_reader_if.slave bus
);

  localparam int FLEN = BYTES + SLOW;
  localparam int IW   = $clog2(FLEN);
  localparam int FW   = $clog2(BYTES);
  localparam int SW   = $clog2(SLOW);
  localparam int FCW  = $clog2(BYTES + 1);
  localparam int SCW  = $clog2(SLOW + 1);
  localparam int MAXA = (SETUP_CYC > HI_CYC) ? SETUP_CYC : HI_CYC;
  localparam int MAXC = (MAXA > LO_CYC) ? MAXA : LO_CYC;
  localparam int TW   = $clog2(MAXC) + 1;

  localparam logic [FCW-1:0] FFULL = FCW'(BYTES);
  localparam logic [SCW-1:0] SFULL = SCW'(SLOW);
  localparam logic [IW-1:0]  IFAST = IW'(BYTES);
  localparam logic [IW-1:0]  ILAST = IW'(FLEN - 1);

  state_t         state, nxt;
  logic [IW-1:0]  idx, nIdx, sOff;
  logic [FCW-1:0] fCnt, fCntN;
  logic [SCW-1:0] sCnt, sCntN;
  logic [7:0]     fBuf [BYTES];
  logic [7:0]     sBuf [SLOW];
  logic [7:0]     nByte, oDataR;
  logic           strobR, ovfR, errR;
  logic           busyI, fAcc, sAcc, startOk;
  logic           tLoad, tZero, idxInc;
  logic [TW-1:0]  tVal;

  assign busyI   = state inside {SETUP, HIGH, LOW};
  assign fAcc    = bus.fVal && !busyI && (fCnt != FFULL);
  assign sAcc    = bus.sVal && !busyI && (sCnt != SFULL);
  assign fCntN   = fCnt + FCW'(fAcc);
  assign sCntN   = sCnt + SCW'(sAcc);
  assign startOk = bus.start && (state == IDLE)
                && (fCntN == FFULL) && (sCntN == SFULL);

  strob_phase_timer #(.W(TW)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (tLoad),
    .loadVal (tVal),
    .zero    (tZero)
  );

  // next state, phase timer reloads and byte advance
  always_comb begin
    nxt    = state;
    tLoad  = 1'b0;
    tVal   = '0;
    idxInc = 1'b0;
    unique case (state)
      IDLE: if (startOk) begin
        nxt   = SETUP;
        tLoad = 1'b1;
        tVal  = TW'(SETUP_CYC - 1);
      end
      SETUP: if (tZero) begin
        nxt   = HIGH;
        tLoad = 1'b1;
        tVal  = TW'(HI_CYC - 1);
      end
      HIGH: if (tZero) begin
        nxt   = LOW;
        tLoad = 1'b1;
        tVal  = TW'(LO_CYC - 1);
      end
      LOW: if (tZero) begin
        if (idx < ILAST) begin
          nxt    = SETUP;
          tLoad  = 1'b1;
          tVal   = TW'(SETUP_CYC - 1);
          idxInc = 1'b1;
        end else begin
          nxt = DONE;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // byte for the next SETUP entry; byte 0 bypasses a same-clk load
  always_comb begin
    nByte = '0;
    nIdx  = idxInc ? idx + 1'b1 : '0;
    sOff  = nIdx - IFAST;
    if (nIdx < IFAST) begin
      nByte = fBuf[nIdx[FW-1:0]];
    end else begin
      nByte = sBuf[sOff[SW-1:0]];
    end
    if (nIdx == '0 && fAcc && fCnt == '0) begin
      nByte = bus.fData;
    end
  end

  // frame buffers, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (fAcc) fBuf[fCnt[FW-1:0]] <= bus.fData;
    if (sAcc) sBuf[sCnt[SW-1:0]] <= bus.sData;
  end

  // state, counters and registered link outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      fCnt     <= '0;
      sCnt     <= '0;
      oDataR   <= '0;
      strobR   <= 1'b0;
      ovfR     <= 1'b0;
      errR     <= 1'b0;
    end else begin
      state  <= nxt;
      strobR <= (nxt == HIGH);
      ovfR   <= (bus.fVal && !fAcc) || (bus.sVal && !sAcc);
      errR   <= bus.start && !startOk;
      if (nxt == DONE) begin
        fCnt <= '0;
        sCnt <= '0;
      end else begin
        fCnt <= fCntN;
        sCnt <= sCntN;
      end
      if (startOk || idxInc) begin
        idx    <= nIdx;
        oDataR <= nByte;
      end
    end
  end

  assign bus.oData    = oDataR;
  assign bus.strob    = strobR;
  assign bus.busy     = busyI;
  assign bus.done     = (state == DONE);
  assign bus.ovf      = ovfR;
  assign bus.errStart = errR;

endmodule
